mult_result_fifo: RTL

Downstream capture stage for the sequential multiplier, which produces `A*B*7` as a 45-bit result with a one-cycle `done` pulse. The block detects each `done` rising edge, stores the accompanying result in a small synchronous FIFO, and presents results to the consumer through a valid/ready stream. Results are dropped only when the FIFO is full and not being popped, and every drop is flagged.

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_fifo_mem.sv | 30 +++
 rtl/mult_result_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier and its downstream stages.
// The multiplier computes A*B*MULT_CONST on OPERAND_W-bit operands and
// delivers a RESULT_W-bit product.
package mult_pkg;

  localparam int OPERAND_W  = 21;
  localparam int RESULT_W   = 45;
  localparam int MULT_CONST = 7;

  typedef logic [RESULT_W-1:0] mult_result_t;

endpackage : mult_pkg

// File: rtl/mult_fifo_mem.sv
// Register-array storage for the result FIFO: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset; the
// occupancy tracking in the parent decides which entries are meaningful.
module mult_fifo_mem
  import mult_pkg::*;
#(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : mult_fifo_mem

// File: rtl/mult_result_fifo.sv
// Capture stage behind the sequential multiplier: detects each rising edge
// of mul_done, stores the accompanying result in a small FIFO and offers it
// to the consumer as a valid/ready stream. Results arriving while the FIFO
// is full (and not being popped) are dropped and flagged in 'overflow'.
// Optional feature macro: MULT_RESULT_FIFO_DROPCNT_EN adds the saturating
// drop_cnt output.
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int DATA_W = RESULT_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        mul_result,
  input  logic                     mul_done,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef MULT_RESULT_FIFO_DROPCNT_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    $error("mult_result_fifo: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic             done_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;
  logic [DATA_W-1:0] rdata;

  // Output stream handshake: a transfer happens on a rising clk edge where
  // out_valid && out_ready are both high. out_valid/out_data depend only on
  // FIFO state (never on out_ready), and out_data holds the head entry
  // unchanged until that entry is transferred. No bypass: a captured result
  // becomes visible the cycle after its capture edge.
  assign out_valid = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign out_data  = out_valid ? rdata : '0;

  assign capture = mul_done & ~done_q;
  assign pop     = out_valid & out_ready;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Edge detect, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= mul_done;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef MULT_RESULT_FIFO_DROPCNT_EN
  // Saturating count of dropped results; a simultaneous clear restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_cnt <= CNT_W'(1);
      end else if (!(&drop_cnt)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

  mult_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (mul_result),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule : mult_result_fifo
